alu_share_arbiter: RTL and testbench

//  Shares one combinational ALU (a, b, sel -> alu_out) between two requesters.

---
 rtl/alu_share_arbiter.sv | 175 +++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin share of one combinational ALU between two requesters
//
// Two requesters present (a, b, sel) operations; the winner is accepted with a
// single-cycle req<i>_ready in IDLE. Its operands are registered and drive the
// ALU during EXEC. The ALU result is registered into rsp_data and returned to
// the winner with rsp_valid[i] until it asserts rsp_ready[i].
//
// Optional feature macro: ALU_ARB_STATS_EN adds per-requester grant counters.
//
// Ports:
//   clk, rst                    clock (rising edge), asynchronous active-high reset
//   req<i>_valid / req<i>_ready operation request / acceptance pulse (i = 0, 1)
//   req<i>_a, req<i>_b          operands [WIDTH]
//   req<i>_sel                  ALU opcode [SEL_W]
//   rsp_valid[1:0]              one-hot: result on rsp_data belongs to requester i
//   rsp_ready[1:0]              requester i consumes its result
//   rsp_data                    registered ALU result [WIDTH]
//   alu_a, alu_b, alu_sel       registered operands to the shared ALU
//   alu_out                     combinational ALU result
//   busy                        high whenever the FSM is not in IDLE
//   grant_cnt0/1                accepted-op counters [CNT_W] (ALU_ARB_STATS_EN only)

module alu_share_arbiter #(
    parameter int WIDTH = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SEL_W-1:0] req1_sel,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               last_grant;
    logic               grant;
    logic               pick;
    logic               accept;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [SEL_W-1:0]   op_sel;

    // Round-robin choice: on a tie the requester that did not win last time goes.
    always_comb begin
        pick = 1'b0;
        if (req0_valid && req1_valid) begin
            pick = ~last_grant;
        end else if (req1_valid) begin
            pick = 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                // Gated by rst so the ready pulse vanishes the instant reset asserts.
                if ((req0_valid || req1_valid) && !rst) begin
                    state_nxt = EXEC;
                    if (pick) begin
                        req1_ready = 1'b1;
                    end else begin
                        req0_ready = 1'b1;
                    end
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready[grant]) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign accept = req0_ready | req1_ready;
    assign busy   = (state != IDLE);

    // The op registers drive the ALU directly, so the ALU inputs keep the last
    // operation's values outside EXEC instead of returning to zero.
    assign alu_a   = op_a;
    assign alu_b   = op_b;
    assign alu_sel = op_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_sel     <= '0;
            rsp_data   <= '0;
            rsp_valid  <= 2'b00;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        grant  <= pick;
                        op_a   <= pick ? req1_a   : req0_a;
                        op_b   <= pick ? req1_b   : req0_b;
                        op_sel <= pick ? req1_sel : req0_sel;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_out;
                    rsp_valid <= grant ? 2'b10 : 2'b01;
                end
                RESP: begin
                    if (rsp_ready[grant]) begin
                        rsp_valid  <= 2'b00;
                        last_grant <= grant;
                    end
                end
                default: begin
                    rsp_valid <= 2'b00;
                end
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Free-running wrap-around counters of accepted operations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req0_ready) begin
                grant_cnt0 <= grant_cnt0 + 1'b1;
            end
            if (req1_ready) begin
                grant_cnt1 <= grant_cnt1 + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter

module tb_alu_share_arbiter;

    localparam int W = 4;
    localparam int S = 2;
    localparam int C = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [S-1:0] req0_sel, req1_sel;
    logic [1:0]   rsp_valid, rsp_ready;
    logic [W-1:0] rsp_data, alu_a, alu_b, alu_out;
    logic [S-1:0] alu_sel;
    logic         busy;
`ifdef ALU_ARB_STATS_EN
    logic [C-1:0] grant_cnt0, grant_cnt1;
`endif

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(W), .SEL_W(S), .CNT_W(C)) dut (
`ifdef ALU_ARB_STATS_EN
        .grant_cnt0(grant_cnt0),
        .grant_cnt1(grant_cnt1),
`endif
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .busy(busy)
    );

    // External ALU: 00 add, 01 sub, 10 and, 11 xor.
    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [S-1:0] s);
        case (s)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_out = alu_fn(alu_a, alu_b, alu_sel);

    typedef struct {
        int           req;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [S-1:0] sel;
        logic [W-1:0] res;
        int           acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   m_last = 1;
    int   m_cnt0 = 0, m_cnt1 = 0;
    bit   acc0 = 1'b0, acc1 = 1'b0;

    // stimulus controls
    int           p0 = 0, p1 = 0;
    int           rmode = 1;
    bit           fixed = 1'b0;
    logic [W-1:0] fa[2], fb[2];
    logic [S-1:0] fs[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Driver: updates inputs just after each rising edge.
    initial begin
        req0_valid = 0; req1_valid = 0; rsp_ready = 2'b11;
        req0_a = 0; req0_b = 0; req0_sel = 0;
        req1_a = 0; req1_b = 0; req1_sel = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                req0_valid = 0; req1_valid = 0;
            end else begin
                if (acc0) begin req0_valid = 0; acc0 = 0; end
                if (acc1) begin req1_valid = 0; acc1 = 0; end
                if (!req0_valid && $urandom_range(99) < p0) begin
                    req0_valid = 1;
                    req0_a   = fixed ? fa[0] : W'($urandom);
                    req0_b   = fixed ? fb[0] : W'($urandom);
                    req0_sel = fixed ? fs[0] : S'($urandom);
                end
                if (!req1_valid && $urandom_range(99) < p1) begin
                    req1_valid = 1;
                    req1_a   = fixed ? fa[1] : W'($urandom);
                    req1_b   = fixed ? fb[1] : W'($urandom);
                    req1_sel = fixed ? fs[1] : S'($urandom);
                end
            end
            case (rmode)
                0:       rsp_ready = 2'b00;
                1:       rsp_ready = 2'b11;
                default: rsp_ready = 2'($urandom_range(3));
            endcase
        end
    end

    // Monitor / reference model, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            m_last = 1;
            m_cnt0 = 0;
            m_cnt1 = 0;
            acc0   = 0;
            acc1   = 0;
        end else begin
            int   g, eg;
            exp_t e;
            cyc++;
            chk("busy", busy, sb.size() > 0);
            chk("ready_onehot", req0_ready & req1_ready, 0);
`ifdef ALU_ARB_STATS_EN
            chk("grant_cnt0", grant_cnt0, m_cnt0 % 256);
            chk("grant_cnt1", grant_cnt1, m_cnt1 % 256);
`endif
            if (req0_ready || req1_ready) begin
                g  = req1_ready ? 1 : 0;
                eg = (req0_valid && req1_valid) ? 1 - m_last : (req1_valid ? 1 : 0);
                chk("grant", g, eg);
                chk("ready_while_pending", sb.size(), 0);
                e.req = g;
                e.a   = g ? req1_a : req0_a;
                e.b   = g ? req1_b : req0_b;
                e.sel = g ? req1_sel : req0_sel;
                e.res = alu_fn(e.a, e.b, e.sel);
                e.acc_cyc = cyc;
                sb.push_back(e);
                if (g == 1) begin acc1 = 1; m_cnt1++; end
                else        begin acc0 = 1; m_cnt0++; end
            end
            if (sb.size() > 0) begin
                e = sb[0];
                if (cyc <= e.acc_cyc + 1) begin
                    chk("rsp_valid_early", rsp_valid, 0);
                    if (cyc == e.acc_cyc + 1) begin
                        chk("alu_a", alu_a, e.a);
                        chk("alu_b", alu_b, e.b);
                        chk("alu_sel", alu_sel, e.sel);
                    end
                end else begin
                    chk("rsp_valid", rsp_valid, 2'b01 << e.req);
                    chk("rsp_data", rsp_data, e.res);
                    if (rsp_ready[e.req]) begin
                        void'(sb.pop_front());
                        m_last = e.req;
                    end
                end
            end else begin
                chk("rsp_valid_idle", rsp_valid, 0);
            end
        end
    end

    task automatic wait_acc();
        int n = 0;
        while (sb.size() == 0 && n < 100) begin
            @(negedge clk); #1; n++;
        end
        chk("accept_timeout", n < 100, 1);
    endtask

    task automatic drain();
        int n = 0;
        p0 = 0; p1 = 0; rmode = 1;
        while ((sb.size() != 0 || busy || req0_valid || req1_valid) && n < 300) begin
            @(negedge clk); #1; n++;
        end
        chk("drain_timeout", n < 300, 1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #3;
        rst = 1;
        #1;
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_alu", {alu_a, alu_b, alu_sel}, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #2;
        rst = 0;
    endtask

    initial begin
        int n;
        rst = 1;
        repeat (2) @(posedge clk);
        #2 rst = 0;
        #1;
        chk("init_busy", busy, 0);
        chk("init_rsp_valid", rsp_valid, 0);
        chk("init_alu", {alu_a, alu_b, alu_sel}, 0);

        // single op from requester 0
        fixed = 1;
        fa[0] = 4'b0111; fb[0] = 4'b0001; fs[0] = 2'b00;
        p0 = 100;
        wait_acc();
        p0 = 0;
        drain();

        // continuous tie: grants must alternate
        fa[0] = 4'b0101; fb[0] = 4'b0011; fs[0] = 2'b01;
        fa[1] = 4'b0100; fb[1] = 4'b0010; fs[1] = 2'b11;
        p0 = 100; p1 = 100;
        repeat (24) @(negedge clk);
        drain();

        // backpressure: result held, nothing accepted meanwhile
        fa[0] = 4'b1100; fb[0] = 4'b1010; fs[0] = 2'b10;
        rmode = 0;
        p0 = 100;
        wait_acc();
        p0 = 0; p1 = 100;
        repeat (8) @(negedge clk);
        drain();

        // idle
        n = 0;
        repeat (10) begin
            @(negedge clk); #1;
            if (busy || rsp_valid != 0 || req0_ready || req1_ready) n++;
        end
        chk("idle_quiet", n, 0);

        // random traffic with a reset in the middle
        fixed = 0; rmode = 2; p0 = 50; p1 = 50;
        repeat (400) @(negedge clk);
        p0 = 100; p1 = 100;
        pulse_reset();
        repeat (3) @(negedge clk);
        p0 = 40; p1 = 60;
        repeat (300) @(negedge clk);
        drain();

        // 258 ops from requester 1 only
        pulse_reset();
        rmode = 1; p0 = 0; p1 = 100;
        n = 0;
        while (m_cnt1 < 258 && n < 2000) begin
            @(negedge clk); #1; n++;
        end
        p1 = 0;
        chk("stats_timeout", n < 2000, 1);
        drain();
        chk("ops_req1", m_cnt1, 258);
`ifdef ALU_ARB_STATS_EN
        chk("stats_cnt1_wrap", grant_cnt1, 2);
        chk("stats_cnt0_zero", grant_cnt0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
